// File: rtl/buffer_rsize_read_sequencer.sv
// buffer_rsize_read_sequencer: issues a run of wrapping RAM reads, tracks read latency, streams words out through a credit-protected skid FIFO
// Ports: clk/rstn (async active-low); start/base_addr/length command (sampled in IDLE);
//        busy/done status; raddr/rdata buffer RAM read port; out_valid/out_data/out_ready output stream.
module buffer_rsize_read_sequencer #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 512,
  parameter int DEPTHAD      = $clog2(DEPTH),
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [DEPTHAD-1:0] base_addr,
  input  logic [DEPTHAD:0]   length,
  output logic               busy,
  output logic               done,
  output logic [DEPTHAD-1:0] raddr,
  input  logic [WIDTH-1:0]   rdata,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [PW-1:0]      LAST_P = PW'(FIFO_DEPTH - 1);
  localparam logic [DEPTHAD-1:0] LAST_A = DEPTHAD'(DEPTH - 1);
  localparam logic [DEPTHAD:0]   LEN1   = 1;
  localparam logic [CW-1:0]      FD     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]      CNT1   = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             r_state, w_next;
  logic [DEPTHAD:0]   r_left;
  logic [DEPTHAD-1:0] r_raddr;
  logic [READ_LATENCY:0] r_vpipe;
  logic [CW-1:0]      r_inflight, r_count;
  logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wp, r_rp;
  logic               r_done;
  logic               w_start_run, w_pop, w_push, w_credit, w_issue, w_last;

  // The first read of a run goes out in the start cycle itself, which gives
  // the length + READ_LATENCY + 2 start-to-done time.
  assign w_start_run = (r_state == IDLE) && start && (length != '0);
  assign w_pop       = (r_count != '0) && out_ready;
  // Bit 0 of the valid pipe lines up with the raddr register, so the top bit
  // marks the cycle the RAM presents that address's data.
  assign w_push      = r_vpipe[READ_LATENCY];
  // A word popped this cycle frees its slot immediately, keeping one issue per
  // cycle sustainable with a FIFO of READ_LATENCY+2 entries.
  assign w_credit    = (r_inflight + r_count - CW'(w_pop)) < FD;
  assign w_issue     = w_start_run || ((r_state == ISSUE) && w_credit);
  assign w_last      = (r_inflight == '0) && ((r_count == '0) || ((r_count == CNT1) && w_pop));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = (r_state == IDLE)  ? (w_start_run ? ((length == LEN1) ? DRAIN : ISSUE) : IDLE) :
             (r_state == ISSUE) ? ((w_issue && (r_left == LEN1)) ? DRAIN : ISSUE) :
             (w_last ? IDLE : DRAIN);
  end

  always_comb begin
    busy      = (r_state != IDLE);
    done      = r_done;
    raddr     = r_raddr;
    out_valid = (r_count != '0);
    out_data  = r_mem[r_rp];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_done     <= 1'b0;
      r_vpipe    <= '0;
      r_raddr    <= '0;
      r_left     <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_done     <= ((r_state == DRAIN) && w_last) || ((r_state == IDLE) && start && (length == '0));
      r_vpipe    <= {r_vpipe[READ_LATENCY-1:0], w_issue};
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_start_run) begin
        r_raddr <= base_addr;
        r_left  <= length - LEN1;
      end else if (w_issue) begin
        r_raddr <= (r_raddr == LAST_A) ? '0 : r_raddr + 1'b1;
        r_left  <= r_left - LEN1;
      end
      if (w_push) begin
        r_mem[r_wp] <= rdata;
        r_wp        <= (r_wp == LAST_P) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) r_rp <= (r_rp == LAST_P) ? '0 : r_rp + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(w_push && (r_count == FD)))
    else $error("skid FIFO overflow: push while full");
endmodule

// File: tb/tb_buffer_rsize_read_sequencer.sv
// tb_buffer_rsize_read_sequencer: directed runs with a RAM model and a scoreboard of expected words
module tb_buffer_rsize_read_sequencer;
  localparam int WIDTH = 32, DEPTH = 512, AW = 9, L = 2, FD = L + 2;

  logic             clk = 1'b0, rstn = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW:0]      length = '0;
  logic             busy, done, out_valid;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata, out_data;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_p [L];
  logic [WIDTH-1:0] exp_q [$];
  int n_chk = 0, n_fail = 0;

  buffer_rsize_read_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READ_LATENCY(L)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_p[0] <= mem[raddr];
    for (int i = 1; i < L; i++) rd_p[i] <= rd_p[i-1];
  end
  assign rdata = rd_p[L-1];

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_raddr"}, longint'(raddr), 0);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_data"}, longint'(out_data), 0);
  endtask

  function automatic logic rdy_of(input int mode, input int c);
    return (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : (c > 20);
  endfunction

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: ready low for 20 cycles.
  // inj: extra start while busy; abort_at: reset after that many beats.
  task automatic run(input int base, input int len, input int mode, input bit inj, input int abort_at);
    int c, done_c, last_beat, beats, chg, chg20, chg_exp;
    logic busy_bad;
    logic [AW-1:0] prev;
    for (int k = 0; k < len; k++) exp_q.push_back(mem[(base + k) % DEPTH]);
    prev = raddr;
    chg_exp = len - ((len > 0 && base == int'(prev)) ? 1 : 0);
    done_c = -1; last_beat = -1; beats = 0; chg = 0; chg20 = 0; busy_bad = 1'b0;
    out_ready = rdy_of(mode, 0);
    start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len);
    @(posedge clk) #1;
    start = 1'b0;
    for (c = 1; c < 400 && done_c < 0; c++) begin
      out_ready = rdy_of(mode, c);
      if (inj && c == 3) begin start = 1'b1; base_addr = AW'(300); length = (AW+1)'(5); end
      @(negedge clk);
      if (raddr !== prev) begin chg++; if (c <= 20) chg20++; prev = raddr; end
      if (mode == 0 && c <= len) chk("raddr_seq", longint'(raddr), longint'((base + c - 1) % DEPTH));
      if (done) done_c = c;
      if (busy !== ((len != 0) && !done)) busy_bad = 1'b1;
      if (out_valid && out_ready) begin
        last_beat = c;
        beats++;
        if (exp_q.size() == 0) chk("extra_word", longint'(out_data), -1);
        else chk("data", longint'(out_data), longint'(exp_q.pop_front()));
        if (abort_at > 0 && beats == abort_at) begin
          @(posedge clk) #1;
          rstn = 1'b0;
          #1;
          chk_reset_outputs("abort");
          exp_q.delete();
          repeat (2) @(negedge clk);
          rstn = 1'b1;
          @(posedge clk) #1;
          return;
        end
      end
      @(posedge clk) #1;
      start = 1'b0;
    end
    chk("done_seen", longint'(done_c > 0), 1);
    if (len > 0) chk("done_after_last_beat", done_c, last_beat + 1);
    if (mode == 0) chk("run_time", done_c, (len > 0) ? len + L + 2 : 1);
    chk("busy_profile", longint'(busy_bad), 0);
    chk("beats", beats, len);
    chk("raddr_issues", chg, chg_exp);
    if (mode == 2) chk("stall_issues", chg20, FD);
    chk("words_left", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk) #1;
    run(0, 8, 0, 1'b0, 0);
    run(508, 8, 0, 1'b0, 0);
    run(20, 16, 1, 1'b0, 0);
    run(200, 10, 2, 1'b0, 0);
    run(40, 0, 0, 1'b0, 0);
    run(60, 12, 0, 1'b1, 0);
    run(0, 16, 0, 1'b0, 3);
    run(100, 4, 0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
